beta_regfile_sb: RTL and testbench
==================================

// Module: beta_regfile_sb
// PURPOSE
//   Parametrised Beta register file. Replaces the fixed 2-read/1-write file in the core.
//   Provides NRD combinational read ports with write-through bypass and a hard-wired zero register.
//   Adds a per-register pending-write scoreboard: issue marks a destination, writeback retires it.
//   RF stage stalls on per-port "ready" flags instead of external hazard logic.
// PARAMETERS
//   DATA_W   32  register width in bits
//   NREGS    32  number of architectural registers (power of 2); AW = $clog2(NREGS)
//   NRD      2   number of read ports (1..4)
//   ZERO_REG 31  index that always reads 0 and ignores writes and issues
//   PEND_W   2   width of per-register pending counter (max in-flight writes = 2**PEND_W-1)
//   BYPASS   1   1: same-cycle write data forwarded to reads; 0: reads see old value
// PORTS
//   clk         in   1           rising-edge clock
//   rst         in   1           asynchronous reset, ACTIVE-LOW
//   ra          in   NRD*AW      read addresses, port i = ra[i*AW +: AW]
//   rd          out  NRD*DATA_W  read data, port i = rd[i*DATA_W +: DATA_W]
//   rd_ready    out  NRD         port i: register not pending (or bypassed) -> data valid
//   we          in   1           write enable (writeback)
//   wa          in   AW          write address
//   wd          in   DATA_W      write data
//   iss_en      in   1           issue: mark iss_addr pending
//   iss_addr    in   AW          destination of issuing instruction
//   pend_full   out  1           iss_addr counter at max; issue this cycle is refused
//   sb_err      out  1           sticky: overflow or retire of non-pending register
// BEHAVIOUR
//   Reset (rst=0, async): all registers = 0, all pending counters = 0, sb_err = 0.
//     Outputs while in reset: rd = 0 for all ports, rd_ready = all 1s, pend_full = 0.
//   Reads are combinational, 0-cycle latency.
//     rd[i] = 0 when ra[i] == ZERO_REG.
//     If BYPASS && we && wa == ra[i] && wa != ZERO_REG: rd[i] = wd.
//     Otherwise rd[i] = stored value.
//   Writes occur on the rising clk edge when we = 1 and wa != ZERO_REG.
//     Writes to ZERO_REG are silently dropped; its storage is never written.
//   Scoreboard: one PEND_W-bit counter per register. ZERO_REG counter is held at 0.
//     inc = iss_en && iss_addr != ZERO_REG && !pend_full.
//     dec = we && wa != ZERO_REG.
//     Same register, inc && dec in one cycle: counter unchanged.
//     dec with counter == 0: counter stays 0, sb_err set (sticky until reset).
//     inc with counter == max: refused (pend_full = 1 combinationally), sb_err set.
//   rd_ready[i] = (cnt[ra[i]] == 0) || (BYPASS && we && wa == ra[i] && cnt[ra[i]] == 1).
//     rd_ready[i] is always 1 for ZERO_REG.
//   A same-cycle issue to ra[i] does not lower rd_ready[i] until the next cycle
//     (reads see pre-issue state).
//   Multiple reads of the same address are independent; every port gets identical data and ready.
//   Async reset mid-operation discards pending state immediately; no write completes that edge.
// TESTING
//   1. Reset: hold rst=0, set ra={5,31} -> rd={0,0}, rd_ready=2'b11, sb_err=0.
//      Release rst, then repeat the read -> same result.
//   2. Write/read: we=1, wa=5, wd=32'hDEADBEEF, ra0=5, BYPASS=1.
//      -> rd0=DEADBEEF in the same cycle; rd0=DEADBEEF next cycle with we=0.
//   3. Zero reg: we=1, wa=31, wd=32'h1234 -> rd at ra=31 stays 0.
//      iss_en at 31 -> no pend change, no sb_err.
//   4. Scoreboard: iss r3 -> next cycle rd_ready (ra=3) = 0.
//      we=1, wa=3, wd=7 -> rd_ready=1, rd=7 that cycle; cnt=0 after.
//   5. Overflow (PEND_W=2): issue r4 three times -> pend_full=1 on the 4th attempt.
//      sb_err=1; counter stays 3; three writebacks then restore rd_ready=1.
//   6. Simultaneous: cnt[r6]=1, iss_en=1 and we=1 both to r6 -> cnt stays 1, rd_ready=0 next cycle.
//      Then retire with we=1, wa=6 while cnt=0 -> sb_err=1.

Source files
------------

// File: rtl/beta_regfile_sb.sv
// Parametrised Beta register file: NRD combinational read ports with write-through
// bypass, a hard-wired zero register, and a per-register pending-write scoreboard.
`timescale 1ns/1ps
module beta_regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 31,
  parameter int PEND_W   = 2,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD*AW-1:0]     ra,
  output logic [NRD*DATA_W-1:0] rd,
  output logic [NRD-1:0]        rd_ready,
  input  logic                  we,
  input  logic [AW-1:0]         wa,
  input  logic [DATA_W-1:0]     wd,
  input  logic                  iss_en,
  input  logic [AW-1:0]         iss_addr,
  output logic                  pend_full,
  output logic                  sb_err
);

  localparam logic [AW-1:0]     ZERO_ADDR = AW'(ZERO_REG);
  localparam logic [PEND_W-1:0] CNT_MAX   = '1;

  logic [DATA_W-1:0] regs_view [NREGS];
  logic [PEND_W-1:0] cnt_view  [NREGS];

  logic wr_ok;
  logic iss_valid;
  logic iss_full;
  logic inc;
  logic overflow;
  logic underflow;
  logic sb_err_q;
  logic sb_err_d;

  assign wr_ok     = we && (wa != ZERO_ADDR);
  assign iss_valid = iss_en && (iss_addr != ZERO_ADDR);
  assign iss_full  = (iss_addr != ZERO_ADDR) && (cnt_view[iss_addr] == CNT_MAX);
  assign inc       = iss_valid && !iss_full;
  assign overflow  = iss_valid && iss_full;
  // A writeback paired with an issue to the same register nets to zero, so it cannot underflow.
  assign underflow = wr_ok && (cnt_view[wa] == '0) && !(inc && (iss_addr == wa));

  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
      if (gi == ZERO_REG) begin : g_zero
        assign regs_view[gi] = '0;
        assign cnt_view[gi]  = '0;
      end else begin : g_store
        logic [DATA_W-1:0] reg_q;
        logic [DATA_W-1:0] reg_d;
        logic [PEND_W-1:0] cnt_q;
        logic [PEND_W-1:0] cnt_d;
        logic              inc_hit;
        logic              dec_hit;

        assign inc_hit = inc && (iss_addr == AW'(gi));
        assign dec_hit = wr_ok && (wa == AW'(gi));

        always_comb begin
          reg_d = reg_q;
          cnt_d = cnt_q;
          if (dec_hit) begin
            reg_d = wd;
          end
          if (inc_hit && !dec_hit) begin
            cnt_d = cnt_q + PEND_W'(1);
          end else if (dec_hit && !inc_hit && (cnt_q != '0)) begin
            cnt_d = cnt_q - PEND_W'(1);
          end
        end

        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            reg_q <= '0;
            cnt_q <= '0;
          end else begin
            reg_q <= reg_d;
            cnt_q <= cnt_d;
          end
        end

        assign regs_view[gi] = reg_q;
        assign cnt_view[gi]  = cnt_q;
      end
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < NRD; gi++) begin : g_rport
      logic [AW-1:0]     addr;
      logic              hit;
      logic [DATA_W-1:0] rd_data;
      logic              ready;

      assign addr = ra[gi*AW +: AW];
      assign hit  = (BYPASS != 0) && we && (wa == addr) && (addr != ZERO_ADDR);

      // Reads look at pre-issue counters, so a same-cycle issue only shows up next cycle.
      always_comb begin
        rd_data = '0;
        ready   = 1'b1;
        if (rst && (addr != ZERO_ADDR)) begin
          rd_data = hit ? wd : regs_view[addr];
          ready   = (cnt_view[addr] == '0) || (hit && (cnt_view[addr] == PEND_W'(1)));
        end
      end

      assign rd[gi*DATA_W +: DATA_W] = rd_data;
      assign rd_ready[gi]            = ready;
    end
  endgenerate

  assign sb_err_d  = sb_err_q || overflow || underflow;
  assign pend_full = rst && iss_full;
  assign sb_err    = sb_err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_err_q <= 1'b0;
    end else begin
      sb_err_q <= sb_err_d;
    end
  end

endmodule

// File: tb/tb_beta_regfile_sb.sv
// Self-checking bench for beta_regfile_sb: expected output vectors are queued when
// stimulus is driven and compared when the outputs are sampled on the falling edge.
`timescale 1ns/1ps
module tb_beta_regfile_sb;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [9:0]  ra = '0;
  logic [63:0] rd;
  logic [1:0]  rd_ready;
  logic        we = 1'b0;
  logic [4:0]  wa = '0;
  logic [31:0] wd = '0;
  logic        iss_en = 1'b0;
  logic [4:0]  iss_addr = '0;
  logic        pend_full;
  logic        sb_err;

  typedef struct {
    string       name;
    logic [67:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  logic [31:0] m_mem [32];
  logic [1:0]  m_cnt [32];
  logic        m_err;

  localparam logic [31:0] DB = 32'hDEADBEEF;

  beta_regfile_sb dut (
    .clk(clk), .rst(rst), .ra(ra), .rd(rd), .rd_ready(rd_ready),
    .we(we), .wa(wa), .wd(wd), .iss_en(iss_en), .iss_addr(iss_addr),
    .pend_full(pend_full), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  function automatic logic [67:0] pk(input logic [31:0] r1, input logic [31:0] r0,
                                     input logic [1:0] rdy, input logic pf, input logic err);
    return {r1, r0, rdy, pf, err};
  endfunction

  function automatic logic [4:0] pick();
    int k;
    k = $urandom_range(0, 8);
    return (k == 8) ? 5'd31 : 5'(k);
  endfunction

  task automatic set_in(input logic w, input logic [4:0] a, input logic [31:0] d,
                        input logic ie, input logic [4:0] ia,
                        input logic [4:0] r0, input logic [4:0] r1);
    we = w; wa = a; wd = d; iss_en = ie; iss_addr = ia; ra = {r1, r0};
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    logic [67:0] obs;
    for (int s = 0; s < 3; s++) begin
      case (s)
        0: begin rst = 1'b0; set_in(1, 5, 32'hAAAA5555, 1, 7, 5, 31); end
        1: set_in(0, 0, 0, 0, 0, 5, 31);
        default: begin rst = 1'b1; set_in(0, 0, 0, 0, 0, 5, 7); end
      endcase
      exp_q.push_back('{$sformatf("reset_s%0d", s), pk(0, 0, 2'b11, 0, 0)});
      @(negedge clk);
      e = exp_q.pop_front();
      obs = {rd, rd_ready, pend_full, sb_err};
      n_cmp++;
      $display("txn %s obs=%h", e.name, obs);
      if (obs !== e.v) begin
        n_err++;
        $display("FAIL %s: rd1|rd0|rdy|pf|err got %h want %h", e.name, obs, e.v);
      end
      advance();
    end
  endtask

  task automatic test_write_read();
    exp_t e;
    logic [67:0] obs;
    for (int s = 0; s < 3; s++) begin
      case (s)
        0: begin set_in(0, 0, 0, 1, 5, 5, 6); exp_q.push_back('{"wr_issue", pk(0, 0, 2'b11, 0, 0)}); end
        1: begin set_in(1, 5, DB, 0, 0, 5, 5); exp_q.push_back('{"wr_bypass", pk(DB, DB, 2'b11, 0, 0)}); end
        default: begin set_in(0, 0, 0, 0, 0, 5, 6); exp_q.push_back('{"wr_stored", pk(0, DB, 2'b11, 0, 0)}); end
      endcase
      @(negedge clk);
      e = exp_q.pop_front();
      obs = {rd, rd_ready, pend_full, sb_err};
      n_cmp++;
      $display("txn %s obs=%h", e.name, obs);
      if (obs !== e.v) begin
        n_err++;
        $display("FAIL %s: rd1|rd0|rdy|pf|err got %h want %h", e.name, obs, e.v);
      end
      advance();
    end
  endtask

  task automatic test_zero_reg();
    exp_t e;
    logic [67:0] obs;
    for (int s = 0; s < 2; s++) begin
      case (s)
        0: begin set_in(1, 31, 32'h1234, 1, 31, 31, 5); exp_q.push_back('{"zero_wr", pk(DB, 0, 2'b11, 0, 0)}); end
        default: begin set_in(0, 0, 0, 0, 31, 31, 31); exp_q.push_back('{"zero_after", pk(0, 0, 2'b11, 0, 0)}); end
      endcase
      @(negedge clk);
      e = exp_q.pop_front();
      obs = {rd, rd_ready, pend_full, sb_err};
      n_cmp++;
      $display("txn %s obs=%h", e.name, obs);
      if (obs !== e.v) begin
        n_err++;
        $display("FAIL %s: rd1|rd0|rdy|pf|err got %h want %h", e.name, obs, e.v);
      end
      advance();
    end
  endtask

  task automatic test_scoreboard();
    exp_t e;
    logic [67:0] obs;
    for (int s = 0; s < 4; s++) begin
      case (s)
        0: begin set_in(0, 0, 0, 1, 3, 3, 5); exp_q.push_back('{"sb_issue", pk(DB, 0, 2'b11, 0, 0)}); end
        1: begin set_in(0, 0, 0, 0, 3, 3, 5); exp_q.push_back('{"sb_pending", pk(DB, 0, 2'b10, 0, 0)}); end
        2: begin set_in(1, 3, 7, 0, 3, 3, 5); exp_q.push_back('{"sb_wb_bypass", pk(DB, 7, 2'b11, 0, 0)}); end
        default: begin set_in(0, 0, 0, 0, 3, 3, 5); exp_q.push_back('{"sb_retired", pk(DB, 7, 2'b11, 0, 0)}); end
      endcase
      @(negedge clk);
      e = exp_q.pop_front();
      obs = {rd, rd_ready, pend_full, sb_err};
      n_cmp++;
      $display("txn %s obs=%h", e.name, obs);
      if (obs !== e.v) begin
        n_err++;
        $display("FAIL %s: rd1|rd0|rdy|pf|err got %h want %h", e.name, obs, e.v);
      end
      advance();
    end
  endtask

  task automatic test_overflow();
    exp_t e;
    logic [67:0] obs;
    for (int s = 0; s < 9; s++) begin
      case (s)
        0: begin set_in(0, 0, 0, 1, 4, 4, 5); exp_q.push_back('{"ovf_iss1", pk(DB, 0, 2'b11, 0, 0)}); end
        1: begin set_in(0, 0, 0, 1, 4, 4, 5); exp_q.push_back('{"ovf_iss2", pk(DB, 0, 2'b10, 0, 0)}); end
        2: begin set_in(0, 0, 0, 1, 4, 4, 5); exp_q.push_back('{"ovf_iss3", pk(DB, 0, 2'b10, 0, 0)}); end
        3: begin set_in(0, 0, 0, 1, 4, 4, 5); exp_q.push_back('{"ovf_iss4_full", pk(DB, 0, 2'b10, 1, 0)}); end
        4: begin set_in(0, 0, 0, 0, 4, 4, 5); exp_q.push_back('{"ovf_err", pk(DB, 0, 2'b10, 1, 1)}); end
        5: begin set_in(1, 4, 32'h11, 0, 4, 4, 5); exp_q.push_back('{"ovf_wb1", pk(DB, 32'h11, 2'b10, 1, 1)}); end
        6: begin set_in(1, 4, 32'h22, 0, 4, 4, 5); exp_q.push_back('{"ovf_wb2", pk(DB, 32'h22, 2'b10, 0, 1)}); end
        7: begin set_in(1, 4, 32'h33, 0, 4, 4, 5); exp_q.push_back('{"ovf_wb3", pk(DB, 32'h33, 2'b11, 0, 1)}); end
        default: begin set_in(0, 0, 0, 0, 0, 4, 5); exp_q.push_back('{"ovf_done", pk(DB, 32'h33, 2'b11, 0, 1)}); end
      endcase
      @(negedge clk);
      e = exp_q.pop_front();
      obs = {rd, rd_ready, pend_full, sb_err};
      n_cmp++;
      $display("txn %s obs=%h", e.name, obs);
      if (obs !== e.v) begin
        n_err++;
        $display("FAIL %s: rd1|rd0|rdy|pf|err got %h want %h", e.name, obs, e.v);
      end
      advance();
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    logic [67:0] obs;
    for (int s = 0; s < 2; s++) begin
      case (s)
        0: begin
          set_in(1, 5, 32'h1111, 0, 0, 4, 5);
          #2 rst = 1'b0;
          exp_q.push_back('{"arst_mid", pk(0, 0, 2'b11, 0, 0)});
        end
        default: begin
          rst = 1'b1;
          set_in(0, 0, 0, 0, 0, 5, 4);
          exp_q.push_back('{"arst_cleared", pk(0, 0, 2'b11, 0, 0)});
        end
      endcase
      @(negedge clk);
      e = exp_q.pop_front();
      obs = {rd, rd_ready, pend_full, sb_err};
      n_cmp++;
      $display("txn %s obs=%h", e.name, obs);
      if (obs !== e.v) begin
        n_err++;
        $display("FAIL %s: rd1|rd0|rdy|pf|err got %h want %h", e.name, obs, e.v);
      end
      advance();
    end
  endtask

  task automatic test_simultaneous();
    exp_t e;
    logic [67:0] obs;
    for (int s = 0; s < 6; s++) begin
      case (s)
        0: begin set_in(0, 0, 0, 1, 6, 6, 31); exp_q.push_back('{"sim_issue", pk(0, 0, 2'b11, 0, 0)}); end
        1: begin set_in(1, 6, 32'h66, 1, 6, 6, 31); exp_q.push_back('{"sim_iss_wb", pk(0, 32'h66, 2'b11, 0, 0)}); end
        2: begin set_in(0, 0, 0, 0, 6, 6, 31); exp_q.push_back('{"sim_still_pend", pk(0, 32'h66, 2'b10, 0, 0)}); end
        3: begin set_in(1, 6, 32'h77, 0, 6, 6, 31); exp_q.push_back('{"sim_retire", pk(0, 32'h77, 2'b11, 0, 0)}); end
        4: begin set_in(1, 6, 32'h88, 0, 6, 6, 31); exp_q.push_back('{"sim_underflow", pk(0, 32'h88, 2'b11, 0, 0)}); end
        default: begin set_in(0, 0, 0, 0, 6, 6, 31); exp_q.push_back('{"sim_err_sticky", pk(0, 32'h88, 2'b11, 0, 1)}); end
      endcase
      @(negedge clk);
      e = exp_q.pop_front();
      obs = {rd, rd_ready, pend_full, sb_err};
      n_cmp++;
      $display("txn %s obs=%h", e.name, obs);
      if (obs !== e.v) begin
        n_err++;
        $display("FAIL %s: rd1|rd0|rdy|pf|err got %h want %h", e.name, obs, e.v);
      end
      advance();
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [67:0] obs;
    logic w, ie, pf, inc, dec;
    logic [4:0] a, ia, r[2];
    logic [31:0] d, dv[2];
    logic [1:0] rv;
    set_in(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    #2 rst = 1'b1;
    for (int i = 0; i < 32; i++) begin
      m_mem[i] = '0;
      m_cnt[i] = '0;
    end
    m_err = 1'b0;
    for (int s = 0; s < 60; s++) begin
      w = 1'($urandom_range(0, 1)); a = pick(); d = $urandom;
      ie = 1'($urandom_range(0, 1)); ia = pick(); r[0] = pick(); r[1] = pick();
      if (w && a != 5'd31 && m_cnt[a] == 2'd0 && $urandom_range(0, 7) != 0) w = 1'b0;
      for (int p = 0; p < 2; p++) begin
        if (r[p] == 5'd31) begin
          dv[p] = '0;
          rv[p] = 1'b1;
        end else if (w && a == r[p]) begin
          dv[p] = d;
          rv[p] = (m_cnt[r[p]] <= 2'd1);
        end else begin
          dv[p] = m_mem[r[p]];
          rv[p] = (m_cnt[r[p]] == 2'd0);
        end
      end
      pf = (ia != 5'd31) && (m_cnt[ia] == 2'd3);
      set_in(w, a, d, ie, ia, r[0], r[1]);
      exp_q.push_back('{$sformatf("b2b_%0d", s), pk(dv[1], dv[0], rv, pf, m_err)});
      inc = ie && ia != 5'd31 && !pf;
      dec = w && a != 5'd31;
      if ((ie && ia != 5'd31 && pf) || (dec && m_cnt[a] == 2'd0 && !(inc && ia == a))) m_err = 1'b1;
      if (!(inc && dec && ia == a)) begin
        if (inc) m_cnt[ia] = m_cnt[ia] + 2'd1;
        if (dec && m_cnt[a] != 2'd0) m_cnt[a] = m_cnt[a] - 2'd1;
      end
      if (dec) m_mem[a] = d;
      @(negedge clk);
      e = exp_q.pop_front();
      obs = {rd, rd_ready, pend_full, sb_err};
      n_cmp++;
      $display("txn %s obs=%h", e.name, obs);
      if (obs !== e.v) begin
        n_err++;
        $display("FAIL %s: rd1|rd0|rdy|pf|err got %h want %h", e.name, obs, e.v);
      end
      advance();
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_write_read();
    test_zero_reg();
    test_scoreboard();
    test_overflow();
    test_async_reset();
    test_simultaneous();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
